video_plane_writer: RTL and testbench
=====================================

# video_plane_writer

Packs a stream of 4-bit Lynx pixels into the four video bit-plane bytes and writes them to video RAM, one byte per plane per 8 pixels. It is the write-side counterpart of the video shifter, which reads the same planes on banks 0–3 (blue, red, greenx, green). It fills a whole frame buffer from any pixel source: screen restore, test-pattern generator or blitter.

## Interface
- LINE_BYTES, default 32: bytes per line per plane (256 pixels / 8).
- LINES, default 248: lines per frame.
- ADDR_W, default 13: byte address width. Must satisfy LINE_BYTES*LINES <= 2^ADDR_W.
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame at address 0. Honoured only in IDLE.
- pvalid  in  1  pixel valid.
- pready  out  1  pixel ready; a pixel transfers when pvalid && pready.
- pix  in  4  pixel {red, green, blue, greenx}. The first pixel of a byte is leftmost and lands in bit 7.
- wvalid  out  1  RAM write request.
- wready  in  1  RAM accepts; a beat transfers when wvalid && wready.
- wbank  out  2  plane: 0 blue, 1 red, 2 greenx, 3 green.
- waddr  out  ADDR_W  byte index within the plane, 0..LINE_BYTES*LINES-1.
- wdata  out  8  plane byte.
- busy  out  1  high from the cycle after an accepted start until the frame completes.
- done  out  1  one-cycle pulse when the last byte of the frame is written.

## Operation
- States: IDLE, COLLECT, WRITE.
- IDLE:
  - pready=0, wvalid=0, busy=0.
  - start=1 → COLLECT; byte address cleared to 0; pixel count cleared to 0.
- COLLECT:
  - pready=1.
  - Each accepted pixel shifts pix[3], pix[2], pix[1], pix[0] into the red, green, blue and greenx shift registers respectively, entering at bit 0 and moving toward bit 7.
  - A 3-bit pixel counter increments on each accept. On the 8th accept (counter 7), the state moves to WRITE with beat counter 0.
- WRITE:
  - pready=0, wvalid=1.
  - wbank = beat counter. wdata = the plane register selected by the bank. waddr = current byte address.
  - wbank, waddr and wdata are held stable while wready=0.
  - Each accepted beat increments the beat counter. The order is strictly 0,1,2,3.
  - After beat 3 is accepted:
    - If the address is not final: address+1, then COLLECT.
    - If the address equals LINE_BYTES*LINES-1: done=1 for one cycle, address wraps to 0, then IDLE.
- start is ignored outside IDLE.
- pvalid is ignored outside COLLECT.
- wready is ignored while wvalid=0.
- Reset (reset=0 at a rising edge), in any state:
  - Goes to IDLE.
  - Clears all counters, shift registers, address and outputs.
  - A partially collected byte is discarded; no write beat is issued for it.

## Timing
- Reset values: pready=0, wvalid=0, wbank=0, waddr=0, wdata=0, busy=0, done=0.
- pready and busy go high on the cycle after the start pulse.
- wvalid goes high on the cycle after the 8th pixel accept.
- With wready tied high, the 4 beats take 4 consecutive cycles. pready returns on the cycle after the beat-3 accept.
- Best-case throughput is 8 pixels per 12 cycles. There is no overlap between collecting and writing.
- done is asserted on the cycle after the final beat-3 accept. busy drops in that same cycle. A start in that cycle is ignored; a start on the next cycle is honoured.
- Frame length: LINE_BYTES*LINES*4 write beats; addresses are monotonic with no gaps.

## Test plan
- **Reset:** hold reset=0 for 3 cycles with pvalid=1 and start=1.
  - All outputs must be 0 and the state IDLE.
  - After release with start low, pready stays 0.
- **Solid red:** start, then 8 pixels of 4'b1000 with wready=1.
  - Required beats at waddr 0: (bank 0, 0x00), (bank 1, 0xFF), (bank 2, 0x00), (bank 3, 0x00) in 4 consecutive cycles.
  - pready is high again on the next cycle.
- **Bit order:** pixels blue (4'b0010), black, blue, black, … ×8, then greenx (4'b0001) only on the 8th pixel of the next byte.
  - Byte 0: bank 0 = 0xAA.
  - Byte 1: bank 2 = 0x01 at waddr 1.
- **Backpressure:** during byte 0, wready=0 for 5 cycles while beat 1 is presented.
  - wvalid=1, wbank=1, waddr=0 and wdata stay stable throughout.
  - pready=0 throughout.
  - Beat 2 follows the cycle after wready rises.
- **Frame end:** LINE_BYTES=2, LINES=2; 32 pixels.
  - waddr sequence 0,1,2,3 with 16 beats total.
  - done is a single pulse after the 16th beat, and busy falls with it.
  - A start pulsed mid-frame has no effect.
  - A second frame then restarts at waddr 0.
- **Reset mid-collect:** 5 pixels of 4'b1111, then reset=0 for one cycle, then start and 8 pixels of 4'b0100.
  - First beats: bank 0 = 0x00, bank 1 = 0x00, bank 2 = 0x00, bank 3 = 0xFF, all at waddr 0.

Source files
------------

// File: rtl/video_plane_writer_if.sv
// video_plane_writer_if: pixel-in, RAM-write-out and frame-control bundle for the plane writer.
// Ports: start/busy/done (frame control), pvalid/pready/pix (pixel stream),
//        wvalid/wready/wbank/waddr/wdata (plane-byte writes to video RAM).
interface video_plane_writer_if #(
  parameter int ADDR_W = 13
);
  // frame control
  logic              start;
  logic              busy;
  logic              done;
  // pixel stream, pix = {red, green, blue, greenx}
  logic              pvalid;
  logic              pready;
  logic [3:0]        pix;
  // RAM write port
  logic              wvalid;
  logic              wready;
  logic [1:0]        wbank;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;

  // Controller / pixel source / RAM side.
  modport master (
    output start, pvalid, pix, wready,
    input  busy, done, pready, wvalid, wbank, waddr, wdata
  );

  // Plane writer side.
  modport slave (
    input  start, pvalid, pix, wready,
    output busy, done, pready, wvalid, wbank, waddr, wdata
  );
endinterface

// File: rtl/video_plane_writer.sv
// video_plane_writer: packs 4-bit pixels into blue/red/greenx/green plane bytes and writes them to video RAM.
// Ports: i_clock, i_reset_n (synchronous, active low), bus (slave modport of video_plane_writer_if).
// Latency: 8 pixel accepts, then 4 write beats (bank 0..3) per byte; collect and write never overlap.
// Backpressure: pready only in COLLECT; wbank/waddr/wdata held while wready is low.
module video_plane_writer #(
  parameter int LINE_BYTES = 32,
  parameter int LINES      = 248,
  parameter int ADDR_W     = 13
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  video_plane_writer_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_BYTES * LINES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2
  } state_t;

  state_t            r_state;
  logic [2:0]        r_pix_cnt;
  logic [1:0]        r_beat;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_red;
  logic [7:0]        r_green;
  logic [7:0]        r_blue;
  logic [7:0]        r_greenx;
  logic              r_pready;
  logic              r_wvalid;
  logic [7:0]        r_wdata;
  logic              r_busy;
  logic              r_done;

  logic [1:0]        w_next_beat;
  logic [7:0]        w_next_plane;

  // Plane byte for the beat that follows the current one (bank order 0 blue, 1 red, 2 greenx, 3 green).
  always_comb begin
    w_next_beat  = r_beat + 2'd1;
    w_next_plane = 8'h00;
    case (w_next_beat)
      2'd0: w_next_plane = r_blue;
      2'd1: w_next_plane = r_red;
      2'd2: w_next_plane = r_greenx;
      2'd3: w_next_plane = r_green;
      default: w_next_plane = 8'h00;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_pix_cnt <= '0;
      r_beat    <= '0;
      r_addr    <= '0;
      r_red     <= '0;
      r_green   <= '0;
      r_blue    <= '0;
      r_greenx  <= '0;
      r_pready  <= 1'b0;
      r_wvalid  <= 1'b0;
      r_wdata   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // The done cycle is already IDLE, but a start landing on it is dropped.
          if (bus.start && !r_done) begin
            r_state   <= S_COLLECT;
            r_addr    <= '0;
            r_pix_cnt <= '0;
            r_pready  <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        S_COLLECT: begin
          if (bus.pvalid) begin
            // First pixel enters at bit 0 and ends up in bit 7 after 8 shifts.
            r_red     <= {r_red[6:0],    bus.pix[3]};
            r_green   <= {r_green[6:0],  bus.pix[2]};
            r_blue    <= {r_blue[6:0],   bus.pix[1]};
            r_greenx  <= {r_greenx[6:0], bus.pix[0]};
            r_pix_cnt <= r_pix_cnt + 3'd1;
            if (r_pix_cnt == 3'd7) begin
              r_state  <= S_WRITE;
              r_beat   <= 2'd0;
              r_pready <= 1'b0;
              r_wvalid <= 1'b1;
              // Beat 0 is blue, including the pixel being accepted right now.
              r_wdata  <= {r_blue[6:0], bus.pix[1]};
            end
          end
        end
        S_WRITE: begin
          if (bus.wready) begin
            if (r_beat == 2'd3) begin
              r_wvalid <= 1'b0;
              r_beat   <= 2'd0;
              if (r_addr == LAST_ADDR) begin
                r_addr  <= '0;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_addr   <= r_addr + ADDR_W'(1);
                r_pready <= 1'b1;
                r_state  <= S_COLLECT;
              end
            end else begin
              r_beat  <= w_next_beat;
              r_wdata <= w_next_plane;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.pready = r_pready;
  assign bus.wvalid = r_wvalid;
  assign bus.wbank  = r_beat;
  assign bus.waddr  = r_addr;
  assign bus.wdata  = r_wdata;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

endmodule

// File: tb/tb_video_plane_writer.sv
// tb_video_plane_writer: directed vectors for video_plane_writer with a 2x2-byte frame.
// Ports: none (top level); drives the master modport side of the interface.
module tb_video_plane_writer;

  localparam int ADDR_W = 13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  video_plane_writer_if #(.ADDR_W(ADDR_W)) bus ();

  video_plane_writer #(
    .LINE_BYTES(2),
    .LINES     (2),
    .ADDR_W    (ADDR_W)
  ) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  typedef struct packed {
    logic [1:0]        bank;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic [31:0]       cyc;
  } beat_t;

  typedef struct {
    string       name;
    logic [31:0] pixels;  // first pixel in [31:28]
    logic [31:0] exp;     // bank0 in [31:24] .. bank3 in [7:0]
  } vec_t;

  beat_t       q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = 0;
  int          done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Beats are recorded half a cycle before the edge that accepts them.
  always @(negedge clk) begin
    if (bus.wvalid && bus.wready)
      q.push_back('{bank: bus.wbank, addr: bus.waddr, data: bus.wdata, cyc: cyc});
    if (bus.done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int n);
    bus.start  = 1'b0;
    bus.pvalid = 1'b0;
    rst_n      = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
    q.delete();
    done_cnt = 0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_busy", {31'd0, bus.busy}, 32'd1);
    chk("start_pready", {31'd0, bus.pready}, 32'd1);
  endtask

  task automatic send_pixel(input logic [3:0] p);
    int  n;
    bit  acc;
    n = 0;
    acc = 1'b0;
    bus.pvalid = 1'b1;
    bus.pix    = p;
    while (!acc && n < 100) begin
      acc = bus.pready;
      tick();
      n++;
    end
    if (!acc) begin
      errors++;
      $display("FAIL pixel_accept: got no accept, expected accept within 100 cycles");
    end
    bus.pvalid = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int k;
    k = 0;
    while (q.size() < n && k < 200) begin
      tick();
      k++;
    end
    chk("beat_count", q.size(), n);
  endtask

  // Expected plane byte for a byte made of 8 identical pixels p.
  function automatic logic [7:0] solid_plane(input logic [3:0] p, input logic [1:0] bank);
    case (bank)
      2'd0: solid_plane = p[1] ? 8'hFF : 8'h00;
      2'd1: solid_plane = p[3] ? 8'hFF : 8'h00;
      2'd2: solid_plane = p[0] ? 8'hFF : 8'h00;
      default: solid_plane = p[2] ? 8'hFF : 8'h00;
    endcase
  endfunction

  vec_t vecs[5];

  initial begin
    logic [3:0] fp;
    beat_t      b;

    vecs[0] = '{"solid_red",  32'h8888_8888, 32'h00FF_0000};
    vecs[1] = '{"blue_alt",   32'h2020_2020, 32'hAA00_0000};
    vecs[2] = '{"solid_green",32'h4444_4444, 32'h0000_00FF};
    vecs[3] = '{"mixed",      32'h1248_F03C, 32'h4A19_8A29};
    vecs[4] = '{"white",      32'hFFFF_FFFF, 32'hFFFF_FFFF};

    bus.start  = 1'b0;
    bus.pvalid = 1'b0;
    bus.pix    = 4'h0;
    bus.wready = 1'b1;

    // Reset with start and pvalid asserted: every output stays 0.
    rst_n      = 1'b0;
    bus.start  = 1'b1;
    bus.pvalid = 1'b1;
    bus.pix    = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_outputs",
          {bus.pready, bus.wvalid, bus.wbank, 3'd0, bus.waddr, bus.wdata, bus.busy, bus.done, 4'd0},
          32'd0);
    end
    rst_n     = 1'b1;
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("post_reset_pready", {31'd0, bus.pready}, 32'd0);
      chk("post_reset_busy", {31'd0, bus.busy}, 32'd0);
    end
    bus.pvalid = 1'b0;

    // Table: one byte per fresh frame, 4 beats at waddr 0 in consecutive cycles.
    for (int v = 0; v < 5; v++) begin
      do_reset(1);
      do_start();
      for (int k = 0; k < 8; k++) send_pixel(vecs[v].pixels[31-4*k -: 4]);
      wait_beats(4);
      if (q.size() >= 4) begin
        for (int j = 0; j < 4; j++) begin
          chk({vecs[v].name, "_bank"}, {30'd0, q[j].bank}, j);
          chk({vecs[v].name, "_addr"}, {19'd0, q[j].addr}, 32'd0);
          chk({vecs[v].name, "_data"}, {24'd0, q[j].data}, {24'd0, vecs[v].exp[31-8*j -: 8]});
          chk({vecs[v].name, "_cycle"}, q[j].cyc - q[0].cyc, j);
        end
      end
    end

    // Solid red, cycle by cycle.
    do_reset(1);
    do_start();
    for (int k = 0; k < 8; k++) send_pixel(4'b1000);
    chk("red_b0", {bus.wvalid, bus.pready, bus.wbank, bus.wdata}, {1'b1, 1'b0, 2'd0, 8'h00});
    tick();
    chk("red_b1", {bus.wvalid, bus.wbank, bus.wdata}, {1'b1, 2'd1, 8'hFF});
    tick();
    chk("red_b2", {bus.wvalid, bus.wbank, bus.wdata}, {1'b1, 2'd2, 8'h00});
    tick();
    chk("red_b3", {bus.wvalid, bus.wbank, bus.wdata}, {1'b1, 2'd3, 8'h00});
    tick();
    chk("red_pready_back", {bus.wvalid, bus.pready, bus.busy}, {1'b0, 1'b1, 1'b1});

    // Bit order across two bytes.
    do_reset(1);
    do_start();
    for (int k = 0; k < 8; k++) send_pixel((k % 2 == 0) ? 4'b0010 : 4'b0000);
    for (int k = 0; k < 8; k++) send_pixel((k == 7) ? 4'b0001 : 4'b0000);
    wait_beats(8);
    if (q.size() >= 8) begin
      chk("order_b0_data", {24'd0, q[0].data}, 32'hAA);
      b = q[6];
      chk("order_byte1_bank2", {b.bank, 3'd0, b.addr, b.data}, {2'd2, 3'd0, 13'd1, 8'h01});
      b = q[4];
      chk("order_byte1_bank0", {b.bank, 3'd0, b.addr, b.data}, {2'd0, 3'd0, 13'd1, 8'h00});
    end

    // Backpressure on beat 1.
    do_reset(1);
    do_start();
    for (int k = 0; k < 8; k++) send_pixel(4'b1000);
    tick();
    bus.wready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", {bus.wvalid, bus.pready, bus.wbank, 3'd0, bus.waddr, bus.wdata},
          {1'b1, 1'b0, 2'd1, 3'd0, 13'd0, 8'hFF});
    end
    bus.wready = 1'b1;
    tick();
    chk("bp_beat2", {bus.wvalid, bus.wbank, bus.wdata}, {1'b1, 2'd2, 8'h00});
    chk("bp_beat_count", q.size(), 2);

    // Full 4-byte frame, byte j made of pixel j+1, with a stray start mid-frame.
    do_reset(1);
    do_start();
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 8; k++) begin
        if (j == 1 && k == 3) bus.start = 1'b1;
        send_pixel(4'(j + 1));
        bus.start = 1'b0;
      end
      if (j < 3) wait_beats(4 * (j + 1));
    end
    chk("frame_pre_done", {bus.done, bus.busy}, {1'b0, 1'b1});
    repeat (4) tick();
    chk("frame_done_pulse", {bus.done, bus.busy, bus.wvalid, bus.pready}, {1'b1, 1'b0, 1'b0, 1'b0});
    chk("frame_beats", q.size(), 16);
    for (int i = 0; i < 16 && i < q.size(); i++) begin
      fp = 4'(i / 4 + 1);
      chk("frame_addr", {19'd0, q[i].addr}, i / 4);
      chk("frame_bank", {30'd0, q[i].bank}, i % 4);
      chk("frame_data", {24'd0, q[i].data}, {24'd0, solid_plane(fp, 2'(i % 4))});
    end
    bus.start = 1'b1;  // lands on the done cycle: ignored
    tick();
    chk("done_cycle_start_ignored", {bus.busy, bus.done}, {1'b0, 1'b0});
    tick();            // held one more cycle: honoured
    bus.start = 1'b0;
    chk("next_start_honoured", {bus.busy, bus.pready}, {1'b1, 1'b1});
    chk("done_count", done_cnt, 1);
    q.delete();
    for (int k = 0; k < 8; k++) send_pixel(4'b1000);
    wait_beats(4);
    if (q.size() >= 2)
      chk("frame2_first", {q[1].bank, 3'd0, q[1].addr, q[1].data}, {2'd1, 3'd0, 13'd0, 8'hFF});

    // Reset mid-collect discards the partial byte.
    do_reset(1);
    do_start();
    for (int k = 0; k < 5; k++) send_pixel(4'b1111);
    do_reset(1);
    chk("midreset_idle", {bus.busy, bus.pready, bus.wvalid}, 3'd0);
    do_start();
    for (int k = 0; k < 8; k++) send_pixel(4'b0100);
    wait_beats(4);
    repeat (3) tick();
    chk("midreset_no_extra", q.size(), 4);
    if (q.size() >= 4) begin
      for (int j = 0; j < 4; j++)
        chk("midreset_beat", {q[j].bank, 3'd0, q[j].addr, q[j].data},
            {2'(j), 3'd0, 13'd0, (j == 3) ? 8'hFF : 8'h00});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
